// File: rtl/key_mode_select.sv
// Debounced two-button mode selector driving the LED control stage's mode index.
// Define KEY_LONGPRESS_EN to let a long hold of either key return the mode to 0.
module key_mode_select #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MODE_MAX        = 3,
  parameter int LONG_CYCLES     = 100_000_000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       key_next_n,
  input  logic       key_prev_n,
  output logic [3:0] cntl,
  output logic       cntl_upd
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    MODE_TOP = 4'(MODE_MAX);
  localparam logic [3:0]    MODE_ONE = 4'd1;

  if (DEBOUNCE_CYCLES < 2) begin : g_badDebounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (MODE_MAX < 1 || MODE_MAX > 15) begin : g_badModeMax
    $error("MODE_MAX must be in 1..15");
  end
  if (LONG_CYCLES < 2) begin : g_badLong
    $error("LONG_CYCLES must be at least 2");
  end

  // Bit 0 carries the "next" key, bit 1 the "previous" key throughout.
  logic [1:0]    w_keyRaw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_deb;
  logic [1:0]    r_press;
  logic [CW-1:0] r_cnt [2];
  logic          w_longFire;
  logic [3:0]    w_nextMode;

  assign w_keyRaw = {key_prev_n, key_next_n};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
      r_deb   <= 2'b11;
      r_press <= 2'b00;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_keyRaw;
      r_sync2 <= r_sync1;
      r_press <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          // Only the falling debounced edge is a press; release is silent.
          r_deb[i]   <= r_sync2[i];
          r_cnt[i]   <= '0;
          r_press[i] <= ~r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

`ifdef KEY_LONGPRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic [HW-1:0] r_hold [2];

  // Counting one past the fire point and stopping there makes it fire once per hold.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_deb[i]) r_hold[i] <= '0;
        else if (r_hold[i] != HOLD_SAT) r_hold[i] <= r_hold[i] + HOLD_ONE;
      end
    end
  end

  assign w_longFire = (r_hold[0] == HOLD_FIRE) || (r_hold[1] == HOLD_FIRE);
`else
  assign w_longFire = 1'b0;
`endif

  always_comb begin
    w_nextMode = cntl;
    if (w_longFire) begin
      w_nextMode = 4'd0;
    end else if (r_press == 2'b01) begin
      w_nextMode = (cntl == MODE_TOP) ? 4'd0 : cntl + MODE_ONE;
    end else if (r_press == 2'b10) begin
      w_nextMode = (cntl == 4'd0) ? MODE_TOP : cntl - MODE_ONE;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cntl     <= 4'd0;
      cntl_upd <= 1'b0;
    end else begin
      cntl     <= w_nextMode;
      cntl_upd <= (w_nextMode != cntl);
    end
  end

endmodule

// File: tb/tb_key_mode_select.sv
// Directed bench for key_mode_select with DEBOUNCE_CYCLES=4, MODE_MAX=3, LONG_CYCLES=20.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_key_mode_select;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       keyNext = 1'b1;
  logic       keyPrev = 1'b1;
  logic [3:0] cntl;
  logic       cntlUpd;

  int total    = 0;
  int bad      = 0;
  int updCount = 0;
  int updBase  = 0;

  always #5 sys_clk = ~sys_clk;

  key_mode_select #(
    .DEBOUNCE_CYCLES(4),
    .MODE_MAX       (3),
    .LONG_CYCLES    (20)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .key_next_n(keyNext),
    .key_prev_n(keyPrev),
    .cntl      (cntl),
    .cntl_upd  (cntlUpd)
  );

  // Tally of update strobes, settled well before the next falling edge.
  always @(posedge sys_clk) begin
    #2;
    if (cntlUpd === 1'b1) updCount++;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic applyStimulus(input logic nextLevel, input logic prevLevel, input int holdCycles);
    keyNext = nextLevel;
    keyPrev = prevLevel;
    waitCycles(holdCycles);
    keyNext = 1'b1;
    keyPrev = 1'b1;
    waitCycles(10);
  endtask

  initial begin
    #1;
    checkOutput("resetCntl", 8'(cntl), 8'd0);
    checkOutput("resetUpd", 8'(cntlUpd), 8'd0);
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(2);

    // First press: new value lands on the 7th edge after the first low sample.
    updBase = updCount;
    keyNext = 1'b0;
    waitCycles(6);
    checkOutput("lat6Cntl", 8'(cntl), 8'd0);
    checkOutput("lat6Upd", 8'(cntlUpd), 8'd0);
    waitCycles(1);
    checkOutput("lat7Cntl", 8'(cntl), 8'd1);
    checkOutput("lat7Upd", 8'(cntlUpd), 8'd1);
    waitCycles(1);
    checkOutput("updWidth", 8'(cntlUpd), 8'd0);
    waitCycles(2);
    keyNext = 1'b1;
    waitCycles(10);
    checkOutput("releaseCntl", 8'(cntl), 8'd1);
    checkOutput("firstPressUpds", 8'(updCount - updBase), 8'd1);

    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("step2", 8'(cntl), 8'd2);
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("step3", 8'(cntl), 8'd3);
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("wrapNext", 8'(cntl), 8'd0);
    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("wrapPrev", 8'(cntl), 8'd3);
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("backToZero", 8'(cntl), 8'd0);

    // Three-cycle lows never reach the four-cycle debounce threshold.
    updBase = updCount;
    for (int k = 0; k < 4; k++) begin
      keyNext = 1'b0;
      waitCycles(3);
      keyNext = 1'b1;
      waitCycles(1);
    end
    waitCycles(10);
    checkOutput("glitchCntl", 8'(cntl), 8'd0);
    checkOutput("glitchUpds", 8'(updCount - updBase), 8'd0);

    updBase = updCount;
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("bothCntl", 8'(cntl), 8'd0);
    checkOutput("bothUpds", 8'(updCount - updBase), 8'd0);

    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("preReset", 8'(cntl), 8'd2);

    // Asynchronous reset in the middle of a debounce, key kept held throughout.
    keyNext = 1'b0;
    waitCycles(4);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midResetCntl", 8'(cntl), 8'd0);
    checkOutput("midResetUpd", 8'(cntlUpd), 8'd0);
    waitCycles(3);
    checkOutput("heldResetCntl", 8'(cntl), 8'd0);
    rst_n = 1'b1;
    waitCycles(6);
    checkOutput("postReset6", 8'(cntl), 8'd0);
    waitCycles(1);
    checkOutput("postReset7", 8'(cntl), 8'd1);
    checkOutput("postReset7Upd", 8'(cntlUpd), 8'd1);
    keyNext = 1'b1;
    waitCycles(10);

    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("holdStart", 8'(cntl), 8'd2);

    updBase = updCount;
    keyNext = 1'b0;
    waitCycles(7);
    checkOutput("holdStep", 8'(cntl), 8'd3);
    checkOutput("holdStepUpd", 8'(cntlUpd), 8'd1);
`ifdef KEY_LONGPRESS_EN
    waitCycles(18);
    checkOutput("longBefore", 8'(cntl), 8'd3);
    waitCycles(1);
    checkOutput("longZero", 8'(cntl), 8'd0);
    checkOutput("longZeroUpd", 8'(cntlUpd), 8'd1);
    waitCycles(14);
    keyNext = 1'b1;
    waitCycles(10);
    checkOutput("longFinal", 8'(cntl), 8'd0);
    checkOutput("longUpds", 8'(updCount - updBase), 8'd2);
`else
    waitCycles(33);
    keyNext = 1'b1;
    waitCycles(10);
    checkOutput("noRepeatCntl", 8'(cntl), 8'd3);
    checkOutput("noRepeatUpds", 8'(updCount - updBase), 8'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
